out_change_capture: RTL and testbench

- Downstream consumer of a 32-bit output register driven by a generated state-machine module, e.g. `out1` of the unit-test FSMs.
- Samples that value every clock and records each change as a {timestamp, value} entry in a small FIFO.
- Exposes the FIFO through a valid/ready read port, giving benches and later stages a synthesizable replacement for `$monitor`-style change logging.

---
 rtl/out_capture_pkg.sv | 21 ++
 rtl/capture_fifo.sv | 90 +++++++++
 rtl/out_change_capture.sv | 169 ++++++++++++++++
 tb/tb_out_change_capture.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/out_capture_pkg.sv
// Shared types and default sizes for the output-change capture block.
//   state_e : capture FSM states
//   entry_t : one logged change {stamp, data} at the default widths
package out_capture_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_TS_W   = 16;
  localparam int unsigned DEF_DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    TRACK
  } state_e;

  typedef struct packed {
    logic [DEF_TS_W-1:0]   stamp;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO with a registered head entry.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   push_i/push_data_i : write request and entry
//   pop_i              : consumer ready; pops only while the head is valid
//   full_o, empty_o    : occupancy flags
//   count_o            : number of stored entries (own register)
//   head_valid_o/head_data_o : registered head entry
module capture_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       head_valid_o,
  output logic [WIDTH-1:0]           head_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_acc, pop_acc;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign rd_next = rd_ptr_q + 1'b1;

  assign pop_acc  = pop_i && valid_q;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_acc = push_i && (!full_o || pop_acc);

  always_comb begin
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Head register tracks what mem[rd_ptr] will hold after this edge,
  // bypassing the incoming entry when it becomes the new head.
  always_comb begin
    head_d = head_q;
    if (pop_acc) begin
      if (count_q > ONE_C)  head_d = mem_q[rd_next];
      else if (push_acc)    head_d = push_data_i;
      else                  head_d = '0;
    end else if (push_acc && (count_q == '0)) begin
      head_d = push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_q <= rd_next;
      count_q <= count_d;
      valid_q <= (count_d != '0);
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o      = count_q;
  assign head_valid_o = valid_q;
  assign head_data_o  = head_q;

endmodule

// File: rtl/out_change_capture.sv
// Logs every change of a monitored value as a {timestamp, value} entry in a
// small FIFO read through a valid/ready port.
//   clk, reset (async, active-low)
//   sample_en : monitored value is meaningful (upstream left its initial state)
//   in_data   : monitored value
//   rd_ready  : consumer takes the head entry
//   clr_ovf   : clears sticky overflow (a simultaneous drop wins)
//   rd_valid, rd_data, rd_stamp : registered head entry
//   count     : stored entries
//   overflow  : sticky, a change was dropped while full
// Build option: OUT_CAPTURE_DEGLITCH_EN -- in TRACK a change is logged only
// after holding for 2 sampling edges, with the stamp of the first edge.
module out_change_capture
  import out_capture_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned TS_W   = DEF_TS_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_en,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    rd_ready,
  input  logic                    clr_ovf,
  output logic                    rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic [TS_W-1:0]         rd_stamp,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int unsigned ENT_W = TS_W + DATA_W;
  localparam logic [TS_W-1:0] TS_MAX = '1;

  state_e            state_q, state_d;
  logic [TS_W-1:0]   stamp_q, stamp_d, stamp_inc;
  logic [DATA_W-1:0] last_q, last_d;
  logic              ovf_q, ovf_d;
  logic              push;
  logic [ENT_W-1:0]  push_entry;
  logic              fifo_full, fifo_empty, drop;
  logic [ENT_W-1:0]  head_data;

`ifdef OUT_CAPTURE_DEGLITCH_EN
  logic              pend_v_q, pend_v_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [TS_W-1:0]   pend_stamp_q, pend_stamp_d;
`endif

  assign stamp_inc = (stamp_q == TS_MAX) ? stamp_q : stamp_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    stamp_d    = stamp_q;
    last_d     = last_q;
    push       = 1'b0;
    push_entry = {stamp_q, in_data};
`ifdef OUT_CAPTURE_DEGLITCH_EN
    pend_v_d     = pend_v_q;
    pend_data_d  = pend_data_q;
    pend_stamp_d = pend_stamp_q;
`endif
    case (state_q)
      IDLE: begin
        stamp_d = '0;
`ifdef OUT_CAPTURE_DEGLITCH_EN
        pend_v_d = 1'b0;
`endif
        if (sample_en) state_d = PRIME;
      end
      PRIME: begin
`ifdef OUT_CAPTURE_DEGLITCH_EN
        pend_v_d = 1'b0;
`endif
        if (!sample_en) begin
          state_d = IDLE;
          stamp_d = '0;
        end else begin
          push    = 1'b1;
          last_d  = in_data;
          stamp_d = stamp_inc;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (!sample_en) begin
          state_d = IDLE;
          stamp_d = '0;
        end else begin
          stamp_d = stamp_inc;
`ifdef OUT_CAPTURE_DEGLITCH_EN
          if (in_data == last_q) begin
            pend_v_d = 1'b0;
          end else if (pend_v_q && (in_data == pend_data_q)) begin
            push       = 1'b1;
            push_entry = {pend_stamp_q, in_data};
            last_d     = in_data;
            pend_v_d   = 1'b0;
          end else begin
            // New candidate (or a different one): restart the hold window.
            pend_v_d     = 1'b1;
            pend_data_d  = in_data;
            pend_stamp_d = stamp_q;
          end
`else
          if (in_data != last_q) begin
            push   = 1'b1;
            last_d = in_data;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign drop  = push && fifo_full && !(rd_ready && !fifo_empty);
  assign ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      stamp_q <= '0;
      last_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stamp_q <= stamp_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef OUT_CAPTURE_DEGLITCH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_v_q     <= 1'b0;
      pend_data_q  <= '0;
      pend_stamp_q <= '0;
    end else begin
      pend_v_q     <= pend_v_d;
      pend_data_q  <= pend_data_d;
      pend_stamp_q <= pend_stamp_d;
    end
  end
`endif

  capture_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (reset),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (rd_ready),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (count),
    .head_valid_o (rd_valid),
    .head_data_o  (head_data)
  );

  assign rd_stamp = head_data[ENT_W-1:DATA_W];
  assign rd_data  = head_data[DATA_W-1:0];
  assign overflow = ovf_q;

endmodule

// File: tb/tb_out_change_capture.sv
module tb_out_change_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_en = 1'b0;
  logic [31:0] in_data = '0;
  logic        rd_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [15:0] rd_stamp;
  logic [3:0]  count;
  logic        overflow;

  out_change_capture #(
    .DATA_W (32),
    .DEPTH  (8),
    .TS_W   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .in_data   (in_data),
    .rd_ready  (rd_ready),
    .clr_ovf   (clr_ovf),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_stamp  (rd_stamp),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] st;
    logic [31:0] d;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
    end
  endtask

  task automatic expect_entry(input logic [15:0] st, input logic [31:0] d);
    exp_t e;
    e.st = st;
    e.d  = d;
    expq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted pop is compared with the oldest expectation.
  always @(negedge clk) begin
    if (reset && rd_valid && rd_ready) begin
      exp_t e;
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: got stamp %0d data 0x%0h, required no entry", rd_stamp, rd_data);
      end else begin
        e = expq.pop_front();
        check("pop_stamp", 32'(rd_stamp), 32'(e.st));
        check("pop_data", rd_data, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", rd_data, 32'd0);
    check("rst_stamp", 32'(rd_stamp), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;

    // Disabled sampling: toggling input records nothing
    for (int i = 0; i < 5; i++) begin
      in_data = 32'(i % 2);
      step();
      check("idle_count", 32'(count), 32'd0);
      check("idle_valid", 32'(rd_valid), 32'd0);
    end

    // Prime then one change
    sample_en = 1'b1;
    in_data = 32'd0;
    step();                       // IDLE -> PRIME
    check("prime_none_yet", 32'(count), 32'd0);
    expect_entry(16'd0, 32'd0);
    step();                       // PRIME records {0,0}
    in_data = 32'd2;
    step();
    step();
    step();
    expect_entry(16'd1, 32'd2);
    check("two_count", 32'(count), 32'd2);
    check("two_valid", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1;
    step();
    step();
    rd_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);
    // timestamp is now 6

`ifndef OUT_CAPTURE_DEGLITCH_EN
    // Fill past capacity
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h100 + 32'(i);
      if (i < 8) expect_entry(16'(6 + i), 32'h100 + 32'(i));
      step();
    end
    check("full_count", 32'(count), 32'd8);
    check("full_ovf", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);

    // Push and pop together while full (stamp 17)
    rd_ready = 1'b1;
    in_data = 32'h200;
    expect_entry(16'd17, 32'h200);
    step();
    rd_ready = 1'b0;
    check("fullpp_count", 32'(count), 32'd8);
    check("fullpp_ovf", 32'(overflow), 32'd0);
    check("fullpp_head_data", rd_data, 32'h101);
    check("fullpp_head_stamp", 32'(rd_stamp), 32'd7);

    rd_ready = 1'b1;
    repeat (5) step();
    rd_ready = 1'b0;
    check("three_left", 32'(count), 32'd3);
`else
    // One-cycle glitch is ignored; held change keeps its first stamp
    sample_en = 1'b0;
    step();
    sample_en = 1'b1;
    in_data = 32'd5;
    step();
    expect_entry(16'd0, 32'd5);
    step();
    in_data = 32'd7;
    step();
    in_data = 32'd5;
    step();
    in_data = 32'd9;
    step();
    step();
    expect_entry(16'd3, 32'd9);
    step();
    check("dg_count", 32'(count), 32'd2);
`endif

    // Asynchronous reset mid-stream
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 32'(rd_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_data", rd_data, 32'd0);
    check("arst_stamp", 32'(rd_stamp), 32'd0);
    expq.delete();
    sample_en = 1'b0;
    in_data = 32'h33;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_valid", 32'(rd_valid), 32'd0);

    // Re-prime after reset
    sample_en = 1'b1;
    step();
    check("reprime_none", 32'(count), 32'd0);
    expect_entry(16'd0, 32'h33);
    step();
    check("reprime_count", 32'(count), 32'd1);
    step();
    step();

    // Dropping sample_en resets the timestamp; re-entry primes at stamp 0
    sample_en = 1'b0;
    step();
    check("reidle_count", 32'(count), 32'd1);
    sample_en = 1'b1;
    in_data = 32'h44;
    step();
    expect_entry(16'd0, 32'h44);
    step();
    check("reentry_count", 32'(count), 32'd2);
    rd_ready = 1'b1;
    step();
    step();
    rd_ready = 1'b0;
    check("final_count", 32'(count), 32'd0);
    check("scoreboard_empty", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
